axi_skid_module: RTL and testbench
==================================

Name: axi_skid_module

Overview:
- Fully registered valid/ready pipeline stage with a 2-entry skid buffer.
- valid_o, data_o and ready_o all come straight from flops, so the block breaks both the forward and the backward timing paths.
- Each captured beat is decoded as data_i − 1, the inverse of the +1 stage. This block sits downstream of that stage as the receive end of the same stream.

Parameters:
DWIDTH, 8, data bus width in bits (≥1)

Ports:
aclk_i  input  1  clock; all logic on rising edge
areset_i  input  1  synchronous, active-high reset
valid_i  input  1  upstream beat valid
data_i  input  DWIDTH  upstream beat payload
ready_o  output  1  upstream ready; registered, no combinational path from ready_i
valid_o  output  1  downstream beat valid; registered
data_o  output  DWIDTH  downstream payload (decoded); registered
ready_i  input  1  downstream ready
level_o  output  2  occupancy: 0, 1 or 2 beats held

Behaviour:
- Reset is synchronous, active-high, and applied at the aclk_i edge while areset_i=1:
  - state=EMPTY, valid_o=0, data_o=0, level_o=0, skid register=0, ready_o=0.
  - ready_o rises to 1 on the first edge with areset_i=0.
- Handshakes:
  - in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
  - A transfer occurs only on a fire at a rising edge.
- Decode:
  - Stored value = data_i − 1, modulo 2^DWIDTH, computed at capture time.
  - 0 wraps to all-ones; no carry or flag output.
- Storage:
  - Main register drives data_o.
  - Skid register holds a second beat when the downstream stalls.
- State machine (state held in flops; level_o = 0/1/2 for EMPTY/BUSY/FULL):
  - EMPTY: valid_o=0, ready_o=1. in_fire → main ← decoded, goto BUSY.
  - BUSY: valid_o=1, ready_o=1.
    - in_fire & out_fire → main ← decoded, stay BUSY.
    - in_fire & !out_fire → skid ← decoded, goto FULL, ready_o←0.
    - !in_fire & out_fire → goto EMPTY, valid_o←0.
    - Neither → hold.
  - FULL: valid_o=1, ready_o=0.
    - out_fire → main ← skid, goto BUSY, ready_o←1.
    - Otherwise hold.
    - in_fire cannot occur (ready_o=0); valid_i is ignored.
- Latency and throughput:
  - 1 cycle from in_fire (in EMPTY) to valid_o=1.
  - Sustained 1 beat/cycle when ready_i=1.
- Ordering: strict FIFO; no beat is dropped or duplicated.
- Stability: while valid_o=1 & ready_i=0, data_o and valid_o hold constant.
- Upstream contract: valid_i/data_i must hold until accepted. The block does not check this.
- Skid register contents are not observable except via data_o after promotion.
- Reset mid-operation: all held beats are discarded, outputs return to reset values on that edge, and no partial beat is emitted afterwards.
- X-safety: data_i is not sampled unless in_fire.

Test Plan:
- Single beat:
  - Stimulus: from reset, drive valid_i=1, data_i=0x10 for one accepted cycle, ready_i=1.
  - Required: next cycle valid_o=1, data_o=0x0F, level_o=1; then valid_o=0, level_o=0.
- Streaming:
  - Stimulus: ready_i=1, data_i=0x01..0x20 on consecutive cycles.
  - Required: data_o=0x00..0x1F on consecutive cycles, ready_o constantly 1, level_o=1 throughout.
- Backpressure fill:
  - Stimulus: ready_i=0, send 0x05 then 0x06.
  - Required: level_o=2, ready_o=0 one cycle after the second accept, data_o=0x04 held.
  - Stimulus: raise ready_i.
  - Required: 0x04 then 0x05 emitted, ready_o returns to 1 the cycle after the first out_fire.
- Wrap:
  - Stimulus: data_i=0x00.
  - Required: data_o=0xFF; with DWIDTH=4, data_i=0x0 → 0xF.
- Reset in FULL:
  - Stimulus: reach level_o=2, assert areset_i for 1 cycle.
  - Required: valid_o=0, ready_o=0, level_o=0 at that edge; ready_o=1 next edge; no stale beat ever emitted.
- Random soak:
  - Stimulus: 10k cycles, random valid_i/ready_i at 50%.
  - Required: scoreboard matches every output to (input−1) in order; no ready_o combinational dependence on ready_i; data_o stable under stall.

Source files
------------

// File: rtl/axi_skid_module.sv
// Registered valid/ready stage with a 2-entry skid buffer; each beat is stored as data_i - 1.
// Latency: 1 cycle from accept to valid_o. Throughput: 1 beat/cycle while ready_i=1.
// Backpressure: ready_o is a flop that drops once two beats are held. It has no combinational path from ready_i.
module axi_skid_module #(
  parameter int DWIDTH = 8
) (
  input  logic              aclk_i,
  input  logic              areset_i,
  input  logic              valid_i,
  input  logic [DWIDTH-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DWIDTH-1:0] data_o,
  input  logic              ready_i,
  output logic [1:0]        level_o
);

  // The state encoding doubles as the occupancy count driven on level_o.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] main_q, main_d;
  logic [DWIDTH-1:0] skid_q, skid_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;

  logic              in_fire;
  logic              out_fire;
  logic [DWIDTH-1:0] decoded;

  assign in_fire  = valid_i & ready_q;
  assign out_fire = valid_q & ready_i;
  // Modulo 2^DWIDTH, so 0 wraps to all-ones. It is only consumed when in_fire is set.
  assign decoded  = data_i - DWIDTH'(1);

  // Next-state and datapath selection. Every target defaults to holding its value.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = decoded;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = decoded;
        end else if (in_fire) begin
          skid_d  = decoded;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // ready_o is low here, so no new beat can arrive. The skid beat is promoted
        // only when the main beat leaves.
        if (out_fire) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    valid_d = (state_d != EMPTY);
    ready_d = (state_d != FULL);
  end

  // State and output registers. Reset discards held beats, and ready_o stays low for one edge afterwards.
  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign data_o  = main_q;
  assign level_o = state_q;

endmodule

// File: tb/tb_axi_skid_module.sv
// Bench for axi_skid_module: directed scenarios followed by a random soak.
// A queue-based model holds the expected beats; occupancy, valid, ready and data come from that queue.
// Inputs change on the falling edge and outputs are checked before the next rising edge.
module tb_axi_skid_module;

  logic       clk = 1'b0;
  logic       areset_i;
  logic       valid_i;
  logic [7:0] data_i;
  logic       ready_i;
  logic       ready_o, valid_o;
  logic [7:0] data_o;
  logic [1:0] level_o;

  logic       r4, v4;
  logic [3:0] d4;
  logic [1:0] l4;

  int checks = 0;
  int errors = 0;

  // Reference model: beats held by the block, in order, already decoded
  logic [7:0] exp_q[$];
  bit         m_hold;   // one-edge ready_o low window after reset
  bit         last_in;  // previous edge accepted a beat

  always #5 clk = ~clk;

  axi_skid_module #(.DWIDTH(8)) dut (
    .aclk_i(clk), .areset_i(areset_i), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
    .level_o(level_o)
  );

  axi_skid_module #(.DWIDTH(4)) dut4 (
    .aclk_i(clk), .areset_i(areset_i), .valid_i(valid_i), .data_i(data_i[3:0]),
    .ready_o(r4), .valid_o(v4), .data_o(d4), .ready_i(ready_i),
    .level_o(l4)
  );

  function automatic bit m_ready();
    return !m_hold && (exp_q.size() < 2);
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    valid_i = v;
    data_i  = d;
    ready_i = r;
  endtask

  // One clock: update the model at the rising edge and return at the falling edge
  task automatic tick();
    bit in_f, out_f;
    @(posedge clk);
    if (areset_i) begin
      exp_q.delete();
      m_hold  = 1'b1;
      last_in = 1'b0;
    end else begin
      in_f  = valid_i && m_ready();
      out_f = (exp_q.size() > 0) && ready_i;
      if (out_f) void'(exp_q.pop_front());
      if (in_f) exp_q.push_back(data_i - 8'd1);
      m_hold  = 1'b0;
      last_in = in_f;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    areset_i = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready_o); end
    checks++; if (level_o !== 2'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level_o); end
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_o); end
    areset_i = 1'b0;
    tick();
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_rise got %b want 1", ready_o); end
  endtask

  task automatic test_single_beat();
    drive(1'b1, 8'h10, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    #1;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", valid_o); end
    checks++; if (data_o !== 8'h0F) begin errors++; $display("FAIL single_data got %h want 0f", data_o); end
    checks++; if (level_o !== 2'd1) begin errors++; $display("FAIL single_level got %0d want 1", level_o); end
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL single_drain_valid got %b want 0", valid_o); end
    checks++; if (level_o !== 2'd0) begin errors++; $display("FAIL single_drain_level got %0d want 0", level_o); end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 32; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      #1;
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready beat %0d got %b want 1", i, ready_o); end
      tick();
      checks++; if (valid_o !== 1'b1 || data_o !== 8'(i - 1) || level_o !== 2'd1) begin
        errors++; $display("FAIL stream_beat %0d got v=%b d=%h l=%0d want v=1 d=%h l=1", i, valid_o, data_o, level_o, 8'(i - 1));
      end
    end
    drive(1'b0, 8'h00, 1'b1);
    tick();
    checks++; if (level_o !== 2'd0) begin errors++; $display("FAIL stream_drain got %0d want 0", level_o); end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 8'h05, 1'b0);
    tick();
    drive(1'b1, 8'h06, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    #1;
    checks++; if (level_o !== 2'd2) begin errors++; $display("FAIL bp_level got %0d want 2", level_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0", ready_o); end
    checks++; if (data_o !== 8'h04) begin errors++; $display("FAIL bp_data got %h want 04", data_o); end
    tick();
    checks++; if (data_o !== 8'h04 || valid_o !== 1'b1) begin errors++; $display("FAIL bp_hold got v=%b d=%h want v=1 d=04", valid_o, data_o); end
    // Raising ready_i must not combinationally raise ready_o
    drive(1'b0, 8'h00, 1'b1);
    #1;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_comb got %b want 0", ready_o); end
    tick();
    checks++; if (data_o !== 8'h05 || valid_o !== 1'b1) begin errors++; $display("FAIL bp_second got v=%b d=%h want v=1 d=05", valid_o, data_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b want 1", ready_o); end
    tick();
    checks++; if (valid_o !== 1'b0 || level_o !== 2'd0) begin errors++; $display("FAIL bp_drain got v=%b l=%0d want v=0 l=0", valid_o, level_o); end
  endtask

  task automatic test_wrap();
    drive(1'b1, 8'h00, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    #1;
    checks++; if (data_o !== 8'hFF || valid_o !== 1'b1) begin errors++; $display("FAIL wrap8 got v=%b d=%h want v=1 d=ff", valid_o, data_o); end
    checks++; if (d4 !== 4'hF || v4 !== 1'b1) begin errors++; $display("FAIL wrap4 got v=%b d=%h want v=1 d=f", v4, d4); end
    tick();
  endtask

  task automatic test_reset_full();
    drive(1'b1, 8'hA1, 1'b0);
    tick();
    drive(1'b1, 8'hA2, 1'b0);
    tick();
    checks++; if (level_o !== 2'd2) begin errors++; $display("FAIL rstfull_pre got %0d want 2", level_o); end
    areset_i = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    tick();
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b0 || level_o !== 2'd0) begin
      errors++; $display("FAIL rstfull_edge got v=%b r=%b l=%0d want 0 0 0", valid_o, ready_o, level_o);
    end
    areset_i = 1'b0;
    tick();
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rstfull_ready got %b want 1", ready_o); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rstfull_stale cycle %0d got valid %b want 0", i, valid_o); end
    end
  endtask

  task automatic test_random_soak();
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    for (int i = 0; i < 10000; i++) begin
      // An offered beat stays in place until it is accepted
      if (!(valid_i && !last_in)) begin
        valid_i = 1'($urandom_range(0, 1));
        data_i  = 8'($urandom);
      end
      ready_i = 1'($urandom_range(0, 1));
      #1;
      checks++; if (level_o !== 2'(exp_q.size())) begin errors++; $display("FAIL soak_level cyc %0d got %0d want %0d", i, level_o, exp_q.size()); end
      checks++; if (valid_o !== (exp_q.size() > 0)) begin errors++; $display("FAIL soak_valid cyc %0d got %b want %b", i, valid_o, exp_q.size() > 0); end
      checks++; if (ready_o !== m_ready()) begin errors++; $display("FAIL soak_ready cyc %0d got %b want %b", i, ready_o, m_ready()); end
      if (exp_q.size() > 0) begin
        checks++; if (data_o !== exp_q[0]) begin errors++; $display("FAIL soak_data cyc %0d got %h want %h", i, data_o, exp_q[0]); end
      end
      if (prev_stall) begin
        checks++; if (valid_o !== 1'b1 || data_o !== prev_data) begin
          errors++; $display("FAIL soak_stall cyc %0d got v=%b d=%h want v=1 d=%h", i, valid_o, data_o, prev_data);
        end
      end
      prev_stall = (valid_o === 1'b1) && (ready_i == 1'b0);
      prev_data  = data_o;
      tick();
    end
    drive(1'b0, 8'h00, 1'b1);
    tick();
    tick();
    tick();
    checks++; if (level_o !== 2'd0 || exp_q.size() != 0) begin errors++; $display("FAIL soak_drain got l=%0d model=%0d want 0", level_o, exp_q.size()); end
  endtask

  initial begin
    m_hold  = 1'b1;
    last_in = 1'b0;
    areset_i = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    test_reset();
    test_single_beat();
    test_streaming();
    test_backpressure();
    test_wrap();
    test_reset_full();
    test_random_soak();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
